sram_rw_arbiter: RTL and testbench
==================================

Name: sram_rw_arbiter

Overview:
- Controller for one 1RW1R 32x256 SRAM macro with byte write mask; the macro has active-low chip-select and write-enable, inputs registered on posedge, and dout valid late in the cycle after issue.
- Shares the RW port (port 0) between N_REQ requesters using round-robin arbitration.
- Serves one read-only requester on port 1, with a same-address write/read hazard stall.
- Provides a clear FSM that zero-fills the whole array; sits between the kernel/host datapaths and the macro.

Parameters:
- ADDR_WIDTH, 8, SRAM word address width.
- DATA_WIDTH, 32, word width.
- NUM_WMASKS, 4, byte-lane write-mask bits (DATA_WIDTH/8).
- N_REQ, 2, number of port-0 requesters (2..4).

Ports:
- clk  in  1  single clock, drives both macro clocks.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  port-0 request valid, one bit per requester.
- req_ready  out  N_REQ  grant; handshake completes when valid & ready.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_wmask  in  N_REQ*NUM_WMASKS  byte enables per requester.
- req_addr  in  N_REQ*ADDR_WIDTH  address per requester.
- req_wdata  in  N_REQ*DATA_WIDTH  write data per requester.
- resp_valid  out  N_REQ  one-cycle read-data strobe per requester.
- resp_rdata  out  DATA_WIDTH  read data, shared; qualified by resp_valid.
- rd_valid / rd_ready  in / out  1  port-1 read handshake.
- rd_addr  in  ADDR_WIDTH  port-1 address.
- rd_resp_valid  out  1  port-1 data strobe.
- rd_resp_data  out  DATA_WIDTH  port-1 read data.
- clear_start  in  1  pulse: begin zero-fill.
- busy  out  1  clear in progress.
- csb0, web0  out  1  macro port-0 chip-select and write-enable, active low.
- wmask0  out  NUM_WMASKS  macro port-0 write mask.
- addr0  out  ADDR_WIDTH  macro port-0 address.
- din0  out  DATA_WIDTH  macro port-0 write data.
- dout0  in  DATA_WIDTH  macro port-0 read data.
- csb1  out  1  macro port-1 chip-select, active low.
- addr1  out  ADDR_WIDTH  macro port-1 address.
- dout1  in  DATA_WIDTH  macro port-1 read data.

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to IDLE; rr pointer = 0; clear counter = 0.
  - resp_valid = 0, rd_resp_valid = 0, busy = 0, resp/rd data registers = 0.
  - While rst_n=0, csb0 = csb1 = web0 = 1 and all req_ready/rd_ready = 0, regardless of inputs.
- Macro drive:
  - Macro-facing outputs are combinational from the current grant, so a request is issued on the same edge as its handshake.
  - When nothing is granted: csb0=1, web0=1, wmask0=0, addr0/din0 hold 0.
- Arbitration, port 0, FSM in IDLE:
  - At most one req_ready is high per cycle.
  - Search starts at rr pointer; the first valid requester wins.
  - req_ready is high only when the matching req_valid is high.
  - On a handshake, rr = winner+1 mod N_REQ; with no handshake, rr holds.
  - Write: csb0=0, web0=0, wmask0/addr0/din0 from the winner.
  - Read: csb0=0, web0=1.
- Read latency: handshake at edge k -> dout0 captured at edge k+1 -> resp_valid[winner] high for exactly the cycle after edge k+1, with resp_rdata = captured value. Back-to-back reads pipeline at full rate. Writes produce no response.
- Port 1:
  - rd_ready = rst_n & ~hazard; csb1 = ~(rd_valid & rd_ready); addr1 = rd_addr.
  - Same 1-edge capture latency via rd_resp_valid/rd_resp_data.
  - Independent of port 0 and of the clear FSM; it may read during CLEAR, and data read there is whatever the sweep has reached.
- Hazard: a port-0 write granted this cycle to addr0 == rd_addr forces rd_ready=0. Port 1 retries the next cycle; a later read returns the new data.
- Clear FSM, states IDLE -> CLEAR -> IDLE:
  - clear_start in IDLE: enter CLEAR, busy=1, counter=0.
  - In CLEAR, every cycle: csb0=0, web0=0, wmask0 = all ones, din0=0, addr0=counter, counter+1. All req_ready=0.
  - After the write to address 2^ADDR_WIDTH-1 (256 cycles): return to IDLE, busy=0 the next cycle.
  - clear_start while in CLEAR is ignored.
  - A port-0 read response already in flight at CLEAR entry is still delivered.
  - Hazard logic also applies to the clear writes.
- Reset mid-clear: immediate IDLE, busy=0, no further writes; array contents undefined.
- Width rules: address compare is full ADDR_WIDTH; the counter is ADDR_WIDTH+1 bits, and the terminal condition is bit ADDR_WIDTH set.

Decomposition:
- Shared package sram_ctrl_pkg: ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS constants, FSM state enum (IDLE, CLEAR), port-0 request struct (we, wmask, addr, wdata).
- One natural sub-module: rr_arbiter (N_REQ-wide round-robin grant with pointer update); everything else stays in the top.

Test Plan:
- Requester 0 writes addr 0x10 data 0xDEADBEEF mask 4'hF, then reads 0x10 -> resp_valid[0] exactly 2 edges after the read handshake, data 0xDEADBEEF.
- Byte mask: write 0x11223344 full, then write 0xAABBCCDD mask 4'b0101, read -> 0x11BB33DD.
- Both requesters hold valid for 6 cycles -> grants alternate 0,1,0,1,0,1; no cycle grants both; responses route to the correct resp_valid bit.
- Port-0 write to 0x20 and port-1 read of 0x20 in the same cycle -> rd_ready=0 that cycle; the retry returns the new data. A different address is not stalled.
- clear_start after filling addresses 0..255 with nonzero data -> busy high for 256 cycles, req_ready=0 throughout; port-1 reads of 0, 128 and 255 afterwards return 0.
- rst_n low at clear count 100 -> csb0=1, busy=0, and no writes occur after the reset edge.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the 1RW1R SRAM controller slice.
package sram_ctrl_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  typedef struct packed {
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } p0_req_t;

endpackage

// File: rtl/sram_rw_arbiter_rr_arbiter.sv
// Round-robin grant over N_REQ requesters; pointer moves past the winner on each grant.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] valid,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic [PTR_W-1:0] ptr_q;

  always_comb begin
    int unsigned j;
    logic [PTR_W-1:0] jp;
    grant     = '0;
    grant_idx = '0;
    j         = 0;
    jp        = '0;
    if (en) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        j  = (32'(ptr_q) + i) % N_REQ;
        jp = PTR_W'(j);
        if (grant == '0 && valid[jp]) begin
          grant[jp] = 1'b1;
          grant_idx = jp;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (grant != '0) begin
      ptr_q <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_rw_arbiter.sv
// SRAM macro controller: round-robin RW port sharing, read-only port 1 with
// write/read hazard stall, and a zero-fill clear sweep.
module sram_rw_arbiter #(
  parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS,
  parameter int N_REQ      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*NUM_WMASKS-1:0] req_wmask,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]       resp_rdata,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic                        rd_resp_valid,
  output logic [DATA_WIDTH-1:0]       rd_resp_data,
  input  logic                        clear_start,
  output logic                        busy,
  output logic                        csb0,
  output logic                        web0,
  output logic [NUM_WMASKS-1:0]       wmask0,
  output logic [ADDR_WIDTH-1:0]       addr0,
  output logic [DATA_WIDTH-1:0]       din0,
  input  logic [DATA_WIDTH-1:0]       dout0,
  output logic                        csb1,
  output logic [ADDR_WIDTH-1:0]       addr1,
  input  logic [DATA_WIDTH-1:0]       dout1
);

  import sram_ctrl_pkg::*;

  localparam int PTR_W = $clog2(N_REQ);

  clr_state_e             state_q;
  logic [ADDR_WIDTH:0]    cnt_q;
  logic [ADDR_WIDTH:0]    cnt_nxt;
  logic [N_REQ-1:0]       grant;
  logic [PTR_W-1:0]       gnt_idx;
  logic                   arb_en;
  logic                   gnt_any;
  logic                   sel_we;
  logic [NUM_WMASKS-1:0]  sel_wmask;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   hazard;
  logic                   p0_rd_fire;
  logic                   p1_fire;
  logic                   rd0_pend_q;
  logic [PTR_W-1:0]       rd0_idx_q;
  logic                   rd1_pend_q;
  logic [N_REQ-1:0]       resp_valid_q;
  logic [DATA_WIDTH-1:0]  resp_rdata_q;
  logic                   rd_resp_valid_q;
  logic [DATA_WIDTH-1:0]  rd_resp_data_q;

  assign arb_en = rst_n && (state_q == IDLE);

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (arb_en),
    .valid     (req_valid),
    .grant     (grant),
    .grant_idx (gnt_idx)
  );

  assign req_ready = grant;
  assign gnt_any   = |grant;

  always_comb begin
    sel_we    = req_we[gnt_idx];
    sel_wmask = req_wmask[gnt_idx*NUM_WMASKS +: NUM_WMASKS];
    sel_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  // Macro port 0 is driven straight from the grant so issue coincides with the handshake.
  always_comb begin
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    if (rst_n) begin
      if (state_q == CLEAR) begin
        csb0   = 1'b0;
        web0   = 1'b0;
        wmask0 = '1;
        addr0  = cnt_q[ADDR_WIDTH-1:0];
      end else if (gnt_any) begin
        csb0  = 1'b0;
        web0  = ~sel_we;
        addr0 = sel_addr;
        if (sel_we) begin
          wmask0 = sel_wmask;
          din0   = sel_wdata;
        end
      end
    end
  end

  assign p0_rd_fire = gnt_any & ~sel_we;
  assign hazard     = ~csb0 & ~web0 & (addr0 == rd_addr);
  assign rd_ready   = rst_n & ~hazard;
  assign p1_fire    = rd_valid & rd_ready;
  assign csb1       = ~p1_fire;
  assign addr1      = rd_addr;
  assign cnt_nxt    = cnt_q + 1'b1;
  assign busy       = rst_n & (state_q == CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_nxt;
          if (cnt_nxt[ADDR_WIDTH]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // dout is valid late in the cycle after issue, so capture one edge after the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd0_pend_q      <= 1'b0;
      rd0_idx_q       <= '0;
      rd1_pend_q      <= 1'b0;
      resp_valid_q    <= '0;
      resp_rdata_q    <= '0;
      rd_resp_valid_q <= 1'b0;
      rd_resp_data_q  <= '0;
    end else begin
      rd0_pend_q      <= p0_rd_fire;
      rd0_idx_q       <= gnt_idx;
      rd1_pend_q      <= p1_fire;
      resp_valid_q    <= '0;
      rd_resp_valid_q <= rd1_pend_q;
      if (rd0_pend_q) begin
        resp_valid_q[rd0_idx_q] <= 1'b1;
        resp_rdata_q            <= dout0;
      end
      if (rd1_pend_q) rd_resp_data_q <= dout1;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign rd_resp_valid = rd_resp_valid_q;
  assign rd_resp_data  = rd_resp_data_q;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Directed bench for sram_rw_arbiter with a behavioural 1RW1R macro and response scoreboards.
module tb_sram_rw_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int NR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NR-1:0]    req_valid, req_ready, req_we, resp_valid;
  logic [NR*NW-1:0] req_wmask;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    resp_rdata, rd_resp_data, din0, dout0, dout1;
  logic             rd_valid, rd_ready, rd_resp_valid, clear_start, busy;
  logic [AW-1:0]    rd_addr, addr0, addr1;
  logic             csb0, web0, csb1;
  logic [NW-1:0]    wmask0;

  sram_rw_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW), .N_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wmask(req_wmask),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .clear_start(clear_start), .busy(busy),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1)
  );

  // Behavioural macro: registered inputs, dout updated on the issuing edge.
  logic [DW-1:0] mem [256];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < NW; b++) if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
        wr_cnt <= wr_cnt + 1;
      end else begin
        dout0 <= mem[addr0];
      end
    end
    if (!csb1) dout1 <= mem[addr1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [DW-1:0] data; int due; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid != '0) begin
      if (q0.size() == 0) chk("p0_unexpected_resp", 64'(resp_valid), 64'd0);
      else begin
        e0 = q0.pop_front();
        chk("p0_route", 64'(resp_valid), 64'd1 << e0.idx);
        chk("p0_data", 64'(resp_rdata), 64'(e0.data));
        chk("p0_latency", 64'(cyc), 64'(e0.due));
      end
    end
    if (rd_resp_valid === 1'b1) begin
      if (q1.size() == 0) chk("p1_unexpected_resp", 64'(rd_resp_valid), 64'd0);
      else begin
        e1 = q1.pop_front();
        chk("p1_data", 64'(rd_resp_data), 64'(e1.data));
        chk("p1_latency", 64'(cyc), 64'(e1.due));
      end
    end
  end

  task automatic set_req(input int r, input logic v, input logic we, input logic [NW-1:0] m,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r]           = v;
    req_we[r]              = we;
    req_wmask[r*NW +: NW]  = m;
    req_addr[r*AW +: AW]   = a;
    req_wdata[r*DW +: DW]  = d;
  endtask

  task automatic p0_op(input int r, input logic we, input logic [NW-1:0] m,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] exp);
    bit done = 0;
    @(posedge clk); #1;
    set_req(r, 1'b1, we, m, a, d);
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        done = 1;
        chk("p0_csb0", 64'(csb0), 64'd0);
        chk("p0_web0", 64'(web0), 64'(!we));
        chk("p0_addr0", 64'(addr0), 64'(a));
        if (we) begin
          chk("p0_din0", 64'(din0), 64'(d));
          chk("p0_wmask0", 64'(wmask0), 64'(m));
        end else begin
          q0.push_back('{r, exp, cyc + 2});
        end
      end
    end
    if (!done) chk("p0_grant_timeout", 64'(req_ready), 64'd1 << r);
    @(posedge clk); #1;
    set_req(r, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic p1_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bit done = 0;
    @(posedge clk); #1;
    rd_valid = 1'b1;
    rd_addr  = a;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (rd_ready) begin
        done = 1;
        q1.push_back('{0, exp, cyc + 2});
      end
    end
    if (!done) chk("p1_ready_timeout", 64'(rd_ready), 64'd1);
    @(posedge clk); #1;
    rd_valid = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int bad_ready;
    int bad_drive;
    int snap;
    bit hit;

    rst_n = 1'b0; req_valid = '1; req_we = '1; req_wmask = '1; req_addr = '0; req_wdata = '1;
    rd_valid = 1'b1; rd_addr = '0; clear_start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rd_ready", 64'(rd_ready), 64'd0);
    chk("rst_csb0", 64'(csb0), 64'd1);
    chk("rst_web0", 64'(web0), 64'd1);
    chk("rst_csb1", 64'(csb1), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_rd_resp_valid", 64'(rd_resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_rd_resp_data", 64'(rd_resp_data), 64'd0);
    req_valid = '0; req_we = '0; req_wmask = '0; req_wdata = '0; rd_valid = 1'b0; clear_start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_csb0", 64'(csb0), 64'd1);
    chk("idle_wmask0", 64'(wmask0), 64'd0);

    p0_op(0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, '0);
    p0_op(0, 1'b0, 4'h0, 8'h10, '0, 32'hDEADBEEF);

    p0_op(0, 1'b1, 4'hF, 8'h30, 32'h11223344, '0);
    p0_op(0, 1'b1, 4'b0101, 8'h30, 32'hAABBCCDD, '0);
    p0_op(0, 1'b0, 4'h0, 8'h30, '0, 32'h11BB33DD);

    // Requester 1 goes once so the pointer is back at requester 0.
    p0_op(1, 1'b1, 4'hF, 8'h40, 32'h5555AAAA, '0);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, '0, 8'h10, '0);
    set_req(1, 1'b1, 1'b0, '0, 8'h40, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_grant", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      if (i % 2 == 0) q0.push_back('{0, 32'hDEADBEEF, cyc + 2});
      else            q0.push_back('{1, 32'h5555AAAA, cyc + 2});
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);

    set_req(0, 1'b1, 1'b1, 4'hF, 8'h20, 32'hCAFEF00D);
    rd_valid = 1'b1; rd_addr = 8'h20;
    @(negedge clk);
    chk("hz_write_grant", 64'(req_ready), 64'd1);
    chk("hz_stall", 64'(rd_ready), 64'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("hz_retry_ready", 64'(rd_ready), 64'd1);
    q1.push_back('{0, 32'hCAFEF00D, cyc + 2});
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 4'hF, 8'h21, 32'h01234567);
    rd_addr = 8'h10;
    @(negedge clk);
    chk("nohz_write_grant", 64'(req_ready), 64'd1);
    chk("nohz_ready", 64'(rd_ready), 64'd1);
    q1.push_back('{0, 32'hDEADBEEF, cyc + 2});
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    rd_valid = 1'b0;

    for (int a = 0; a < 256; a++) p0_op(0, 1'b1, 4'hF, AW'(a), 32'h5A000000 | 32'(a), '0);
    p1_read(8'd128, 32'h5A000080);

    // Clear entry with a port-0 read granted on the same edge.
    @(posedge clk); #1;
    clear_start = 1'b1;
    set_req(0, 1'b1, 1'b0, '0, 8'h80, '0);
    @(negedge clk);
    chk("clr_entry_grant", 64'(req_ready), 64'd1);
    q0.push_back('{0, 32'h5A000080, cyc + 2});
    @(posedge clk); #1;
    clear_start = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 1'b0, '0, 8'h05, '0);
    busy_cnt = 0; bad_ready = 0; bad_drive = 0; hit = 0;
    for (int t = 0; t < 400 && !hit; t++) begin
      @(negedge clk);
      if (busy) begin
        if (req_ready != '0) bad_ready++;
        if (csb0 !== 1'b0 || web0 !== 1'b0 || wmask0 !== '1 || din0 !== '0 || addr0 !== AW'(busy_cnt))
          bad_drive++;
        busy_cnt++;
        if (busy_cnt == 50) clear_start = 1'b1;
        if (busy_cnt == 52) clear_start = 1'b0;
      end else begin
        hit = 1;
      end
    end
    chk("clr_busy_cycles", 64'(busy_cnt), 64'd256);
    chk("clr_ready_low", 64'(bad_ready), 64'd0);
    chk("clr_macro_drive", 64'(bad_drive), 64'd0);
    chk("clr_exit_grant", 64'(req_ready), 64'd2);
    q0.push_back('{1, 32'h0, cyc + 2});
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    p1_read(8'd0, 32'h0);
    p1_read(8'd128, 32'h0);
    p1_read(8'd255, 32'h0);

    @(posedge clk); #1;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    hit = 0;
    for (int t = 0; t < 300 && !hit; t++) begin
      @(negedge clk);
      if (busy && addr0 == 8'd100) hit = 1;
    end
    chk("mid_clear_reached", 64'(hit), 64'd1);
    rst_n = 1'b0;
    snap  = wr_cnt;
    @(posedge clk); #1;
    chk("mid_rst_csb0", 64'(csb0), 64'd1);
    chk("mid_rst_web0", 64'(web0), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_no_writes", 64'(wr_cnt), 64'(snap));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_csb0", 64'(csb0), 64'd1);
    chk("post_rst_no_writes", 64'(wr_cnt), 64'(snap));

    repeat (4) @(negedge clk);
    chk("p0_queue_drained", 64'(q0.size()), 64'd0);
    chk("p1_queue_drained", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
